data_mem_ctrl: RTL and testbench

- Parametrised, handshaked data-memory controller for the core's load/store stage.
- Successor to the single-cycle byte-array data memory. Adds:
  - configurable depth;
  - synchronous word-organised storage with byte enables;
  - valid/ready request handshake with a registered response;
  - two-beat splitting of word-crossing misaligned accesses;
  - error reporting for out-of-range and illegal-funct3 accesses.

---
 rtl/data_mem_pkg.sv | 44 ++++
 rtl/data_mem_bank.sv | 48 ++++
 rtl/data_mem_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the load/store data-memory controller:
//   - funct3 size encodings and the position of the "unsigned load" bit
//   - response cause codes reported on resp_cause
//   - controller FSM state type
//   - helper that turns a size encoding into a byte count
// ----------------------------------------------------------------------------
package data_mem_pkg;

    // funct3[1:0] access size encodings
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // funct3 bit that selects zero-extension on loads
    localparam int UNSIGNED_BIT = 2;

    // resp_cause encodings
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    // IDLE accepts requests; SECOND performs the high-word beat of a split access
    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    // Number of bytes touched by an access of the given size. The illegal
    // size 11 maps to 4 so that downstream arithmetic stays well defined;
    // such requests are rejected before they reach memory anyway.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/data_mem_bank.sv
// ----------------------------------------------------------------------------
// data_mem_bank
// DEPTH_WORDS x 32-bit synchronous RAM, one read/write port.
//   clock  : rising-edge clock
//   en     : port enable for this cycle
//   we     : 1 = write enabled byte lanes, 0 = read
//   be     : byte-lane enables for writes (lane 0 = bits 7:0)
//   idx    : word index
//   wdata  : write data, already steered onto its byte lanes
//   rdata  : registered read data, valid the cycle after a read
// Contents are deliberately not reset.
// ----------------------------------------------------------------------------
module data_mem_bank #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clock,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Single port: a write updates only the enabled lanes, a read captures the
    // whole word into the output register. The read register holds its value
    // across writes and idle cycles so the controller can keep presenting it.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
// Handshaked data-memory controller for the load/store stage.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake (accept when both high)
//   req_we                  : 1 = store, 0 = load
//   req_funct3              : RV32 load/store funct3
//   req_addr, req_wdata     : byte address, little-endian store data
//   resp_valid              : one-cycle pulse per accepted request
//   resp_rdata              : extended load data, 0 for stores and errors
//   resp_err, resp_cause    : failure flag and reason (see data_mem_pkg)
// Word-crossing accesses are split into two beats when SPLIT_MISALIGNED = 1,
// otherwise they are rejected as misaligned.
// ----------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS      = 256,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_cause
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_CAP = 33'(4 * DEPTH_WORDS);

    // FSM and response flops
    state_e             state_q,      state_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q,   resp_err_d;
    logic [1:0]         resp_cause_q, resp_cause_d;
    // attributes of the request being answered, used to shape resp_rdata
    logic               rsp_load_q,   rsp_load_d;
    logic               rsp_cross_q,  rsp_cross_d;
    logic [1:0]         rsp_off_q,    rsp_off_d;
    logic [1:0]         rsp_size_q,   rsp_size_d;
    logic               rsp_uns_q,    rsp_uns_d;
    // second-beat context of a split access
    logic               hi_we_q,      hi_we_d;
    logic [3:0]         hi_be_q,      hi_be_d;
    logic [31:0]        hi_wdata_q,   hi_wdata_d;
    logic [IDX_W-1:0]   hi_idx_q,     hi_idx_d;
    // low word of a split load
    logic [31:0]        low_q,        low_d;

    // decode results
    logic [1:0]         req_size;
    logic [1:0]         req_off;
    logic [2:0]         req_nbytes;
    logic [IDX_W-1:0]   req_idx;
    logic               illegal;
    logic               fault;
    logic               crossing;
    logic               req_has_err;
    logic [1:0]         req_cause;
    logic [3:0]         size_mask;
    logic [7:0]         be64;
    logic [63:0]        wd64;
    logic [32:0]        last_byte;
    logic               accept;

    // bank port
    logic               bank_en;
    logic               bank_we;
    logic [3:0]         bank_be;
    logic [IDX_W-1:0]   bank_idx;
    logic [31:0]        bank_wdata;
    logic [31:0]        bank_rdata;

    // load-data shaping
    logic [63:0]        rd_window;
    logic [31:0]        rd_shifted;
    logic [31:0]        rd_ext;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Decode the incoming request: legality, range, word crossing, and the
    // byte enables / data laid out over two consecutive words. For a
    // non-crossing access only the low word of that layout is populated.
    always_comb begin
        req_size   = req_funct3[1:0];
        req_off    = req_addr[1:0];
        req_nbytes = size_bytes(req_size);
        req_idx    = req_addr[IDX_W+1:2];

        illegal = (req_size == 2'b11)
               || (req_we && req_funct3[UNSIGNED_BIT])
               || (!req_we && (req_funct3 == 3'b110));

        // 33-bit arithmetic so accesses near the top of the address space
        // cannot wrap back into range
        last_byte = {1'b0, req_addr} + {30'b0, req_nbytes} - 33'd1;
        fault     = (last_byte >= BYTE_CAP);
        crossing  = (({2'b00, req_off} + {1'b0, req_nbytes}) > 4'd4);

        req_has_err = 1'b1;
        if (illegal) begin
            req_cause = CAUSE_ILLEGAL;
        end else if (fault) begin
            req_cause = CAUSE_ACCESS;
        end else if (crossing && !SPLIT_MISALIGNED) begin
            req_cause = CAUSE_MISALIGN;
        end else begin
            req_cause   = CAUSE_NONE;
            req_has_err = 1'b0;
        end

        case (req_size)
            SIZE_B:  size_mask = 4'b0001;
            SIZE_H:  size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be64 = {4'b0000, size_mask} << req_off;
        wd64 = {32'b0, req_wdata} << {req_off, 3'b000};
    end

    // Next-state and bank control. In IDLE an accepted, error-free request
    // drives the bank immediately; a crossing one also captures its high-word
    // beat for SECOND. A reset landing in SECOND suppresses that beat so a
    // half-done store keeps only its low-word bytes.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_cause_d = CAUSE_NONE;
        rsp_load_d   = rsp_load_q;
        rsp_cross_d  = rsp_cross_q;
        rsp_off_d    = rsp_off_q;
        rsp_size_d   = rsp_size_q;
        rsp_uns_d    = rsp_uns_q;
        hi_we_d      = hi_we_q;
        hi_be_d      = hi_be_q;
        hi_wdata_d   = hi_wdata_q;
        hi_idx_d     = hi_idx_q;
        low_d        = low_q;
        bank_en      = 1'b0;
        bank_we      = 1'b0;
        bank_be      = 4'b0000;
        bank_idx     = req_idx;
        bank_wdata   = 32'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_load_d  = !req_we;
                    rsp_cross_d = crossing;
                    rsp_off_d   = req_off;
                    rsp_size_d  = req_size;
                    rsp_uns_d   = req_funct3[UNSIGNED_BIT];
                    if (req_has_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_cause_d = req_cause;
                    end else begin
                        bank_en    = 1'b1;
                        bank_we    = req_we;
                        bank_be    = be64[3:0];
                        bank_wdata = wd64[31:0];
                        if (crossing) begin
                            hi_we_d    = req_we;
                            hi_be_d    = be64[7:4];
                            hi_wdata_d = wd64[63:32];
                            hi_idx_d   = req_idx + 1'b1;
                            state_d    = SECOND;
                        end else begin
                            resp_valid_d = 1'b1;
                        end
                    end
                end
            end
            SECOND: begin
                low_d        = bank_rdata;
                bank_en      = !reset;
                bank_we      = hi_we_q;
                bank_be      = hi_be_q;
                bank_idx     = hi_idx_q;
                bank_wdata   = hi_wdata_q;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
            rsp_load_q   <= 1'b0;
            rsp_cross_q  <= 1'b0;
            rsp_off_q    <= 2'b00;
            rsp_size_q   <= SIZE_B;
            rsp_uns_q    <= 1'b0;
            hi_we_q      <= 1'b0;
            hi_be_q      <= 4'b0000;
            hi_wdata_q   <= 32'b0;
            hi_idx_q     <= '0;
            low_q        <= 32'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_cause_q <= resp_cause_d;
            rsp_load_q   <= rsp_load_d;
            rsp_cross_q  <= rsp_cross_d;
            rsp_off_q    <= rsp_off_d;
            rsp_size_q   <= rsp_size_d;
            rsp_uns_q    <= rsp_uns_d;
            hi_we_q      <= hi_we_d;
            hi_be_q      <= hi_be_d;
            hi_wdata_q   <= hi_wdata_d;
            hi_idx_q     <= hi_idx_d;
            low_q        <= low_d;
        end
    end

    data_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clock (clock),
        .en    (bank_en),
        .we    (bank_we),
        .be    (bank_be),
        .idx   (bank_idx),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Shape load data from registered sources only (bank read register, low
    // word latch and captured request attributes), so nothing on req_* reaches
    // resp_*. A split load sees {high word, low word}; a single-word load sees
    // the bank word alone. Gated to 0 outside a successful load response.
    always_comb begin
        rd_window  = {rsp_cross_q ? bank_rdata : 32'b0,
                      rsp_cross_q ? low_q      : bank_rdata} >> {rsp_off_q, 3'b000};
        rd_shifted = rd_window[31:0];
        case (rsp_size_q)
            SIZE_B:  rd_ext = rsp_uns_q ? {24'b0, rd_shifted[7:0]}
                                        : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            SIZE_H:  rd_ext = rsp_uns_q ? {16'b0, rd_shifted[15:0]}
                                        : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
        resp_rdata = (resp_valid_q && rsp_load_q && !resp_err_q) ? rd_ext : 32'b0;
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_cause = resp_cause_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed bench for data_mem_ctrl. Two instances share clock, reset and the
// request fields: "dut" splits crossing accesses, "dut_ns" rejects them.
// Each has its own req_valid so only one of them sees a given request.
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        ns_req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready,  ns_req_ready;
    logic        resp_valid, ns_resp_valid;
    logic [31:0] resp_rdata, ns_resp_rdata;
    logic        resp_err,   ns_resp_err;
    logic [1:0]  resp_cause, ns_resp_cause;

    int checks_total;
    int checks_passed;

    logic [31:0] rd;
    logic        er;
    logic [1:0]  ca;
    int          lat;
    int          rlow;
    int          rv_seen;

    data_mem_ctrl #(.DEPTH_WORDS(256), .SPLIT_MISALIGNED(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_cause (resp_cause)
    );

    data_mem_ctrl #(.DEPTH_WORDS(256), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (ns_req_valid),
        .req_ready  (ns_req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (ns_resp_valid),
        .resp_rdata (ns_resp_rdata),
        .resp_err   (ns_resp_err),
        .resp_cause (ns_resp_cause)
    );

    // free-running 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request into the selected instance, wait for acceptance and
    // its response. Returns the response fields, the latency in cycles after
    // the acceptance edge, and how many sampled cycles req_ready was low.
    task automatic applyStimulus(input logic ns, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] o_rdata, output logic o_err,
                                 output logic [1:0] o_cause, output int o_lat,
                                 output int o_rlow);
        int guard;
        @(negedge clock);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (ns) ns_req_valid = 1'b1; else req_valid = 1'b1;
        guard = 0;
        while (!(ns ? ns_req_ready : req_ready) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        req_valid    = 1'b0;
        ns_req_valid = 1'b0;
        o_lat  = 1;
        o_rlow = (ns ? ns_req_ready : req_ready) ? 0 : 1;
        while (!(ns ? ns_resp_valid : resp_valid) && o_lat < 10) begin
            @(posedge clock);
            #1;
            o_lat++;
            if (!(ns ? ns_req_ready : req_ready)) o_rlow++;
        end
        if (!(ns ? ns_resp_valid : resp_valid)) checkOutput("resp_timeout", 32'd0, 32'd1);
        o_rdata = ns ? ns_resp_rdata : resp_rdata;
        o_err   = ns ? ns_resp_err   : resp_err;
        o_cause = ns ? ns_resp_cause : resp_cause;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        ns_req_valid = 1'b0;
        req_we       = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'b0;
        req_wdata    = 32'b0;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_err",   {31'b0, resp_err},   32'd0);
        checkOutput("rst_cause", {30'b0, resp_cause}, 32'd0);
        checkOutput("rst_rdata", resp_rdata,          32'd0);
        checkOutput("rst_ready", {31'b0, req_ready},  32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("ready_after_rst",    {31'b0, req_ready},    32'd1);
        checkOutput("ns_ready_after_rst", {31'b0, ns_req_ready}, 32'd1);

        // aligned store, then sub-word loads of the same word
        applyStimulus(0, 1, 3'b010, 32'h10, 32'h80FF_1234, rd, er, ca, lat, rlow);
        checkOutput("sw10_lat",   lat,         32'd1);
        checkOutput("sw10_err",   {31'b0, er}, 32'd0);
        checkOutput("sw10_rdata", rd,          32'd0);
        applyStimulus(0, 0, 3'b000, 32'h12, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lb12",     rd,          32'hFFFF_FFFF);
        checkOutput("lb12_lat", lat,         32'd1);
        checkOutput("lb12_err", {31'b0, er}, 32'd0);
        applyStimulus(0, 0, 3'b100, 32'h12, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lbu12",     rd,  32'h0000_00FF);
        checkOutput("lbu12_lat", lat, 32'd1);
        applyStimulus(0, 0, 3'b001, 32'h12, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lh12",     rd,  32'hFFFF_80FF);
        checkOutput("lh12_lat", lat, 32'd1);
        applyStimulus(0, 0, 3'b101, 32'h10, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lhu10", rd, 32'h0000_1234);
        applyStimulus(0, 0, 3'b000, 32'h11, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lb11", rd, 32'h0000_0012);

        // split store across words 8/9
        applyStimulus(0, 1, 3'b010, 32'h20, 32'h1122_3344, rd, er, ca, lat, rlow);
        applyStimulus(0, 1, 3'b010, 32'h24, 32'h5566_7788, rd, er, ca, lat, rlow);
        applyStimulus(0, 1, 3'b010, 32'h21, 32'hAABB_CCDD, rd, er, ca, lat, rlow);
        checkOutput("sw21_lat",  lat,         32'd2);
        checkOutput("sw21_rlow", rlow,        32'd1);
        checkOutput("sw21_err",  {31'b0, er}, 32'd0);
        applyStimulus(0, 0, 3'b010, 32'h20, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lw20", rd, 32'hBBCC_DD44);
        applyStimulus(0, 0, 3'b010, 32'h24, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lw24", rd, 32'h5566_77AA);
        applyStimulus(0, 0, 3'b010, 32'h21, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lw21_split",     rd,  32'hAABB_CCDD);
        checkOutput("lw21_split_lat", lat, 32'd2);
        applyStimulus(0, 0, 3'b001, 32'h23, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lh23_split", rd, 32'hFFFF_AABB);
        applyStimulus(0, 0, 3'b101, 32'h23, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lhu23_split", rd, 32'h0000_AABB);

        // non-splitting instance: crossing half rejected, memory untouched
        applyStimulus(1, 1, 3'b010, 32'h30, 32'h0102_0304, rd, er, ca, lat, rlow);
        applyStimulus(1, 1, 3'b010, 32'h34, 32'h0506_0708, rd, er, ca, lat, rlow);
        applyStimulus(1, 1, 3'b001, 32'h33, 32'h0000_BEEF, rd, er, ca, lat, rlow);
        checkOutput("ns_sh33_err",   {31'b0, er}, 32'd1);
        checkOutput("ns_sh33_cause", {30'b0, ca}, 32'd1);
        checkOutput("ns_sh33_lat",   lat,         32'd1);
        checkOutput("ns_sh33_rdata", rd,          32'd0);
        applyStimulus(1, 0, 3'b010, 32'h30, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("ns_lw30", rd, 32'h0102_0304);
        applyStimulus(1, 0, 3'b010, 32'h34, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("ns_lw34", rd, 32'h0506_0708);
        applyStimulus(1, 1, 3'b001, 32'h31, 32'h0000_BEEF, rd, er, ca, lat, rlow);
        checkOutput("ns_sh31_err", {31'b0, er}, 32'd0);
        applyStimulus(1, 0, 3'b010, 32'h30, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("ns_lw30_after_sh31", rd, 32'h01BE_EF04);

        // top of memory
        applyStimulus(0, 1, 3'b010, 32'h3FC, 32'hCAFE_F00D, rd, er, ca, lat, rlow);
        applyStimulus(0, 0, 3'b010, 32'h3FC, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lw3fc",     rd,          32'hCAFE_F00D);
        checkOutput("lw3fc_err", {31'b0, er}, 32'd0);
        applyStimulus(0, 1, 3'b010, 32'h3FE, 32'h1234_5678, rd, er, ca, lat, rlow);
        checkOutput("sw3fe_err",   {31'b0, er}, 32'd1);
        checkOutput("sw3fe_cause", {30'b0, ca}, 32'd2);
        checkOutput("sw3fe_lat",   lat,         32'd1);
        applyStimulus(0, 0, 3'b101, 32'h3FE, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lhu3fe_unchanged", rd, 32'h0000_CAFE);
        applyStimulus(0, 0, 3'b000, 32'h400, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lb400_cause", {30'b0, ca}, 32'd2);
        checkOutput("lb400_rdata", rd,          32'd0);

        // illegal funct3, including priority over access fault
        applyStimulus(0, 0, 3'b011, 32'h10, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("ld011_cause", {30'b0, ca}, 32'd3);
        checkOutput("ld011_rdata", rd,          32'd0);
        checkOutput("ld011_err",   {31'b0, er}, 32'd1);
        applyStimulus(0, 1, 3'b100, 32'h10, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("st100_cause", {30'b0, ca}, 32'd3);
        applyStimulus(0, 0, 3'b010, 32'h10, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("lw10_unchanged", rd, 32'h80FF_1234);
        applyStimulus(0, 0, 3'b110, 32'h10, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("ld110_cause", {30'b0, ca}, 32'd3);
        applyStimulus(0, 0, 3'b011, 32'h400, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("ill_over_fault", {30'b0, ca}, 32'd3);

        // reset in the middle of a split store
        applyStimulus(0, 1, 3'b010, 32'h40, 32'h1111_1111, rd, er, ca, lat, rlow);
        applyStimulus(0, 1, 3'b010, 32'h44, 32'h2222_2222, rd, er, ca, lat, rlow);
        @(negedge clock);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h42;
        req_wdata  = 32'hAABB_CCDD;
        req_valid  = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        checkOutput("mid_split_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        rv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (resp_valid) rv_seen++;
        end
        checkOutput("mid_rst_no_resp", rv_seen, 32'd0);
        applyStimulus(0, 0, 3'b010, 32'h40, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("mid_rst_lw40", rd, 32'hCCDD_1111);
        applyStimulus(0, 0, 3'b010, 32'h44, 32'h0, rd, er, ca, lat, rlow);
        checkOutput("mid_rst_lw44", rd, 32'h2222_2222);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
